// File: rtl/systolic_3x3.sv
// ---------------------------------------------------------------------------
// systolic_3x3
//
// Output-stationary 3x3 systolic array computing C = A x B for 3x3 matrices
// of DATA_W-bit unsigned integers. Row operands enter on the left edge and
// move one PE to the right per enabled clock. Column operands enter on the
// top edge and move one PE down per enabled clock. Each PE keeps its own
// running sum in place, and that sum is exposed directly as an output.
//
// The feeder skews the operands so that A[r][k] and B[k][c] meet in PE(r,c)
// on enabled edge k+r+c. Idle slots carry zero, which leaves the
// accumulators unchanged.
//
// Ports
//   CLK         in   1       rising-edge clock
//   RST         in   1       synchronous active-high reset; clears every PE
//                            register and has priority over EN
//   EN          in   1       advance enable; when low, all state holds
//   A0, A3, A6  in   DATA_W  left-edge operands for rows 0, 1 and 2
//   B0, B1, B2  in   DATA_W  top-edge operands for columns 0, 1 and 2
//   C0..C8      out  DATA_W  accumulator of PE(r,c) at index r*3+c
//                            (row-major), driven straight from registers
//
// Arithmetic is unsigned. Each product is truncated to DATA_W bits, and each
// sum wraps modulo 2^DATA_W. There is no saturation and no overflow flag.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// systolic_3x3_pe
//
// A single processing element. It registers the operands passing through it
// and accumulates their product.
//
// Ports
//   clk_i   in   1       rising-edge clock
//   rst_i   in   1       synchronous active-high reset
//   en_i    in   1       advance enable
//   a_i     in   DATA_W  operand arriving from the left neighbour or edge
//   b_i     in   DATA_W  operand arriving from the upper neighbour or edge
//   a_o     out  DATA_W  registered a operand, passed to the right neighbour
//   b_o     out  DATA_W  registered b operand, passed to the lower neighbour
//   acc_o   out  DATA_W  running accumulator
// ---------------------------------------------------------------------------
module systolic_3x3_pe #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [DATA_W-1:0] acc_o
);

  // Multiply-accumulate with modular wrap. The same-width product keeps
  // only the low DATA_W bits. The addition then wraps naturally.
  function automatic logic [DATA_W-1:0] mac_wrap(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] prod;
    prod = a * b;
    return acc + prod;
  endfunction

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] b_d;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (en_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = mac_wrap(acc_q, a_i, b_i);
    end
  end

  // PE register stage: operand hop and accumulator update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

module systolic_3x3 #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] A3,
  input  logic [DATA_W-1:0] A6,
  input  logic [DATA_W-1:0] B0,
  input  logic [DATA_W-1:0] B1,
  input  logic [DATA_W-1:0] B2,
  output logic [DATA_W-1:0] C0,
  output logic [DATA_W-1:0] C1,
  output logic [DATA_W-1:0] C2,
  output logic [DATA_W-1:0] C3,
  output logic [DATA_W-1:0] C4,
  output logic [DATA_W-1:0] C5,
  output logic [DATA_W-1:0] C6,
  output logic [DATA_W-1:0] C7,
  output logic [DATA_W-1:0] C8
);

  // Edge operands gathered into arrays so that the PE grid can be generated.
  logic [DATA_W-1:0] a_left [3];
  logic [DATA_W-1:0] b_top  [3];

  // Per-PE operand inputs, registered operand outputs and accumulators.
  // The rightmost a_fwd column and the bottom b_fwd row are not consumed by
  // any neighbour. They are still kept so that every PE matches the others.
  logic [DATA_W-1:0] a_in  [3][3];
  logic [DATA_W-1:0] b_in  [3][3];
  logic [DATA_W-1:0] a_fwd [3][3];
  logic [DATA_W-1:0] b_fwd [3][3];
  logic [DATA_W-1:0] acc   [3][3];

  assign a_left[0] = A0;
  assign a_left[1] = A3;
  assign a_left[2] = A6;
  assign b_top[0]  = B0;
  assign b_top[1]  = B1;
  assign b_top[2]  = B2;

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      // a comes from the left edge in column 0; otherwise it comes from the
      // registered a of the PE to the left.
      if (c == 0) begin : g_a_edge
        assign a_in[r][c] = a_left[r];
      end else begin : g_a_hop
        assign a_in[r][c] = a_fwd[r][c-1];
      end

      // b comes from the top edge in row 0; otherwise it comes from the
      // registered b of the PE above.
      if (r == 0) begin : g_b_edge
        assign b_in[r][c] = b_top[c];
      end else begin : g_b_hop
        assign b_in[r][c] = b_fwd[r-1][c];
      end

      systolic_3x3_pe #(
        .DATA_W (DATA_W)
      ) u_pe (
        .clk_i (CLK),
        .rst_i (RST),
        .en_i  (EN),
        .a_i   (a_in[r][c]),
        .b_i   (b_in[r][c]),
        .a_o   (a_fwd[r][c]),
        .b_o   (b_fwd[r][c]),
        .acc_o (acc[r][c])
      );
    end
  end

  assign C0 = acc[0][0];
  assign C1 = acc[0][1];
  assign C2 = acc[0][2];
  assign C3 = acc[1][0];
  assign C4 = acc[1][1];
  assign C5 = acc[1][2];
  assign C6 = acc[2][0];
  assign C7 = acc[2][1];
  assign C8 = acc[2][2];

endmodule

// File: tb/tb_systolic_3x3.sv
// ---------------------------------------------------------------------------
// tb_systolic_3x3
//
// Self-checking bench for systolic_3x3. It applies a table of whole-matrix
// vectors, a set of hand-written multi-cycle sequences (partial sums, stall,
// mid-operation reset and wrap-around) and randomized matrices with random
// stalls. Expected results come from a matrix-product model: after enabled
// edge e, C[r][c] is the sum of A[r][k]*B[k][c] over every k with
// k+r+c <= e, taken modulo 2^32.
// ---------------------------------------------------------------------------
module tb_systolic_3x3;

  localparam int DATA_W = 32;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic [8:0][DATA_W-1:0] a;
    logic [8:0][DATA_W-1:0] b;
    logic [8:0][DATA_W-1:0] c;
  } vec_t;

  logic  CLK = 1'b0;
  logic  RST;
  logic  EN;
  word_t A0, A3, A6, B0, B1, B2;
  word_t C0, C1, C2, C3, C4, C5, C6, C7, C8;
  word_t c_arr [9];

  int    n_cmp  = 0;
  int    n_fail = 0;

  word_t ma [9];
  word_t mb [9];

  always #5 CLK = ~CLK;

  systolic_3x3 #(.DATA_W(DATA_W)) dut (
    .CLK (CLK), .RST (RST), .EN (EN),
    .A0  (A0),  .A3  (A3),  .A6 (A6),
    .B0  (B0),  .B1  (B1),  .B2 (B2),
    .C0  (C0),  .C1  (C1),  .C2 (C2),
    .C3  (C3),  .C4  (C4),  .C5 (C5),
    .C6  (C6),  .C7  (C7),  .C8 (C8)
  );

  assign c_arr[0] = C0;
  assign c_arr[1] = C1;
  assign c_arr[2] = C2;
  assign c_arr[3] = C3;
  assign c_arr[4] = C4;
  assign c_arr[5] = C5;
  assign c_arr[6] = C6;
  assign c_arr[7] = C7;
  assign c_arr[8] = C8;

  // Result of PE(r,c) after enabled edge e of feeding ma x mb.
  function automatic word_t model_c(input int r, input int c, input int e);
    word_t s;
    word_t p;
    s = '0;
    for (int k = 0; k < 3; k++) begin
      if (k + r + c <= e) begin
        p = ma[r*3+k] * mb[k*3+c];
        s = s + p;
      end
    end
    return s;
  endfunction

  // Row r receives A[r][k] on edge k+r; column c receives B[k][c] on edge k+c.
  function automatic word_t a_feed(input int r, input int e);
    int k;
    k = e - r;
    return (k >= 0 && k < 3) ? ma[r*3+k] : '0;
  endfunction

  function automatic word_t b_feed(input int c, input int e);
    int k;
    k = e - c;
    return (k >= 0 && k < 3) ? mb[k*3+c] : '0;
  endfunction

  task automatic set_edge(input int e);
    A0 = a_feed(0, e);
    A3 = a_feed(1, e);
    A6 = a_feed(2, e);
    B0 = b_feed(0, e);
    B1 = b_feed(1, e);
    B2 = b_feed(2, e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN  = 1'b1;
    set_edge(-10);
    tick();
    RST = 1'b0;
  endtask

  task automatic check(input string name, input int idx, input word_t exp);
    n_cmp++;
    if (c_arr[idx] !== exp) begin
      n_fail++;
      $display("FAIL %s C%0d: got 0x%08h, required 0x%08h", name, idx, c_arr[idx], exp);
    end
  endtask

  task automatic check_model(input string name, input int e);
    for (int i = 0; i < 9; i++) check(name, i, model_c(i / 3, i % 3, e));
  endtask

  task automatic check_const(input string name, input word_t exp [9]);
    for (int i = 0; i < 9; i++) check(name, i, exp[i]);
  endtask

  // Runs enabled edges first..last, optionally checking against the model
  // after each one.
  task automatic run_edges(input int first, input int last, input bit chk, input string name);
    EN = 1'b1;
    for (int e = first; e <= last; e++) begin
      set_edge(e);
      tick();
      if (chk) check_model(name, e);
    end
  endtask

  word_t ref_a  [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  word_t ref_b  [9] = '{10, 11, 12, 13, 14, 15, 16, 17, 18};
  word_t ref_c  [9] = '{84, 90, 96, 201, 216, 231, 318, 342, 366};
  word_t ident  [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  word_t zeros  [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  word_t exp9   [9];
  vec_t  vecs   [4];

  initial begin
    // The table holds whole-matrix vectors with constant expectations.
    for (int i = 0; i < 9; i++) begin
      vecs[0].a[i] = ref_a[i]; vecs[0].b[i] = ref_b[i]; vecs[0].c[i] = ref_c[i];
      vecs[1].a[i] = ident[i]; vecs[1].b[i] = ref_b[i]; vecs[1].c[i] = ref_b[i];
      vecs[2].a[i] = ref_a[i]; vecs[2].b[i] = ident[i]; vecs[2].c[i] = ref_a[i];
      vecs[3].a[i] = 32'hFFFF_FFFF; vecs[3].b[i] = 32'd1; vecs[3].c[i] = 32'hFFFF_FFFD;
    end

    RST = 1'b1;
    EN  = 1'b0;
    A0 = '0; A3 = '0; A6 = '0; B0 = '0; B1 = '0; B2 = '0;
    tick();
    tick();
    RST = 1'b0;
    check_const("reset", zeros);

    // Table-driven vectors: final result, then hold over idle edges.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 9; i++) begin
        ma[i]   = vecs[v].a[i];
        mb[i]   = vecs[v].b[i];
        exp9[i] = vecs[v].c[i];
      end
      do_reset();
      run_edges(0, 6, 1'b0, "");
      check_const($sformatf("vec%0d_final", v), exp9);
      run_edges(7, 9, 1'b0, "");
      check_const($sformatf("vec%0d_hold", v), exp9);
    end

    // Partial sums after edges 0 and 1 of the reference multiply.
    ma = ref_a;
    mb = ref_b;
    do_reset();
    run_edges(0, 0, 1'b0, "");
    exp9 = zeros; exp9[0] = 32'd10;
    check_const("partial_e0", exp9);
    run_edges(1, 1, 1'b0, "");
    exp9[0] = 32'd36; exp9[1] = 32'd11; exp9[3] = 32'd40;
    check_const("partial_e1", exp9);
    run_edges(2, 6, 1'b1, "ref_edges");

    // Stall for 3 cycles after edge 2, with the inputs held.
    do_reset();
    run_edges(0, 2, 1'b0, "");
    EN = 1'b0;
    set_edge(3);
    for (int s = 0; s < 3; s++) begin
      tick();
      check_model("stall_freeze", 2);
    end
    run_edges(3, 6, 1'b0, "");
    check_const("stall_final", ref_c);

    // Reset in the middle of the operation, then a full re-feed.
    do_reset();
    run_edges(0, 3, 1'b0, "");
    RST = 1'b1;
    set_edge(4);
    tick();
    RST = 1'b0;
    check_const("midrst_clear", zeros);
    run_edges(0, 6, 1'b0, "");
    check_const("midrst_refeed", ref_c);

    // Wrap-around of the product and the accumulator.
    do_reset();
    EN = 1'b1;
    A0 = 32'hFFFF_FFFF; B0 = 32'd2;
    tick();
    check("wrap_e0", 0, 32'hFFFF_FFFE);
    A0 = 32'd1; B0 = 32'd2;
    tick();
    check("wrap_e1", 0, 32'h0000_0000);
    check("wrap_e1", 1, 32'h0000_0000);
    check("wrap_e1", 3, 32'h0000_0000);
    A0 = '0; B0 = '0;

    // Random matrices with random stalls, checked after every cycle.
    for (int t = 0; t < 20; t++) begin
      int e;
      for (int i = 0; i < 9; i++) begin
        ma[i] = (t < 10) ? word_t'($urandom_range(0, 255)) : word_t'($urandom);
        mb[i] = (t < 10) ? word_t'($urandom_range(0, 255)) : word_t'($urandom);
      end
      do_reset();
      e = 0;
      for (int it = 0; it < 40 && e <= 8; it++) begin
        set_edge(e);
        if ($urandom_range(0, 3) == 0) begin
          EN = 1'b0;
          tick();
          check_model("rand_stall", e - 1);
        end else begin
          EN = 1'b1;
          tick();
          check_model("rand_edge", e);
          e++;
        end
      end
      EN = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
